// File: rtl/uart_pkg.sv
// Shared defaults and state encodings for the UART frame assembler.
package uart_pkg;

  localparam int unsigned DBITS_DEF          = 8;
  localparam int unsigned FRAME_BYTES_DEF    = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 0;
  localparam int unsigned PAD_ON_TIMEOUT_DEF = 0;
  localparam logic [7:0]  PAD_BYTE_DEF       = 8'h00;

  // Collection side: IDLE means no partial frame is held.
  typedef enum logic {
    COLL_IDLE    = 1'b0,
    COLL_COLLECT = 1'b1
  } coll_state_e;

  // Output side: FULL means the output register holds an undelivered frame.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/frame_out_reg.sv
// Output register for assembled frames: valid/ready handshake, load-or-drop
// arbitration, sticky overflow and delivered-frame counter.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// OUT_EMPTY | no frame pending; a load request is always accepted
// OUT_FULL  | frame_data is pending; a load is accepted only together with
//           | a completing handshake, otherwise the new frame is dropped
module frame_out_reg
  import uart_pkg::*;
#(
  parameter int unsigned W = FRAME_BYTES_DEF * DBITS_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_req,
  input  logic [W-1:0] load_data,
  input  logic         frame_ready,
  output logic [W-1:0] frame_data,
  output logic         frame_valid,
  output logic [15:0]  frame_count,
  output logic         overflow
);

  out_state_e  state_q, state_d;
  logic [W-1:0] data_q, data_d;
  logic [15:0]  count_q, count_d;
  logic         ovf_q, ovf_d;
  logic         hs;

  // Next-state: handshake frees the register, a load refills it in the same cycle.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    hs      = (state_q == OUT_FULL) && frame_ready;

    if (hs) begin
      count_d = count_q + 16'd1;
      state_d = OUT_EMPTY;
    end

    if (load_req) begin
      if ((state_q == OUT_EMPTY) || hs) begin
        data_d  = load_data;
        state_d = OUT_FULL;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Output FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign frame_data  = data_q;
  assign frame_valid = (state_q == OUT_FULL);
  assign frame_count = count_q;
  assign overflow    = ovf_q;

endmodule

// File: rtl/uart_frame_assembler.sv
// Packs received UART characters into FRAME_BYTES-wide frames, lane 0 first,
// with an optional inter-byte timeout that discards or pads a partial frame.
//
// state        | meaning
// -------------+------------------------------------------------------------
// COLL_IDLE    | byte_count = 0, idle counter frozen
// COLL_COLLECT | 0 < byte_count < FRAME_BYTES, idle counter running
module uart_frame_assembler
  import uart_pkg::*;
#(
  parameter int unsigned      DBITS          = DBITS_DEF,
  parameter int unsigned      FRAME_BYTES    = FRAME_BYTES_DEF,
  parameter int unsigned      TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned      PAD_ON_TIMEOUT = PAD_ON_TIMEOUT_DEF,
  parameter logic [DBITS-1:0] PAD_BYTE       = DBITS'(PAD_BYTE_DEF)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               byte_valid,
  input  logic [DBITS-1:0]                   byte_data,
  output logic [FRAME_BYTES*DBITS-1:0]       frame_data,
  output logic                               frame_valid,
  input  logic                               frame_ready,
  output logic [$clog2(FRAME_BYTES+1)-1:0]   byte_count,
  output logic [15:0]                        frame_count,
  output logic                               overflow,
  output logic                               timeout_err
);

  localparam int unsigned CW         = $clog2(FRAME_BYTES + 1);
  localparam int unsigned FW         = FRAME_BYTES * DBITS;
  localparam int unsigned TW         = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam bit          PAD_EN     = (PAD_ON_TIMEOUT != 0);
  localparam logic [CW-1:0] LAST_LANE = CW'(FRAME_BYTES - 1);
  // The timeout fires on the edge that would take the idle count to TIMEOUT_CYCLES.
  localparam logic [TW-1:0] IDLE_LAST = TIMEOUT_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;

  typedef logic [FRAME_BYTES-1:0][DBITS-1:0] lanes_t;

  coll_state_e   state_q, state_d;
  lanes_t        coll_q, coll_d;
  lanes_t        filled, padded;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          to_err_q, to_err_d;
  logic          to_fire;
  logic          load_req;
  logic [FW-1:0] load_data;

  // Lane images: the frame with the incoming byte written, and the partial frame padded.
  always_comb begin
    filled = coll_q;
    padded = coll_q;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      if (CW'(i) == cnt_q) filled[i] = byte_data;
      if (CW'(i) >= cnt_q) padded[i] = PAD_BYTE;
    end
  end

  // Collection next-state: flush beats a byte, a byte beats the timeout.
  always_comb begin
    coll_d    = coll_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    to_err_d  = 1'b0;
    load_req  = 1'b0;
    load_data = filled;
    to_fire   = TIMEOUT_EN && (state_q == COLL_COLLECT) && !byte_valid && (idle_q == IDLE_LAST);

    if (flush) begin
      coll_d = '0;
      cnt_d  = '0;
      idle_d = '0;
    end else if (byte_valid) begin
      idle_d = '0;
      if (cnt_q == LAST_LANE) begin
        load_req = 1'b1;
        coll_d   = '0;
        cnt_d    = '0;
      end else begin
        coll_d = filled;
        cnt_d  = cnt_q + CW'(1);
      end
    end else if (to_fire) begin
      to_err_d = 1'b1;
      coll_d   = '0;
      cnt_d    = '0;
      idle_d   = '0;
      if (PAD_EN) begin
        load_req  = 1'b1;
        load_data = padded;
      end
    end else if (TIMEOUT_EN && (state_q == COLL_COLLECT)) begin
      idle_d = idle_q + TW'(1);
    end

    state_d = (cnt_d == '0) ? COLL_IDLE : COLL_COLLECT;
  end

  // Collection FSM, collection register, byte counter and idle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLL_IDLE;
      coll_q   <= '0;
      cnt_q    <= '0;
      idle_q   <= '0;
      to_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      coll_q   <= coll_d;
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      to_err_q <= to_err_d;
    end
  end

  frame_out_reg #(
    .W (FW)
  ) u_frame_out_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_req    (load_req),
    .load_data   (load_data),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_count (frame_count),
    .overflow    (overflow)
  );

  assign byte_count  = cnt_q;
  assign timeout_err = to_err_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Bench for uart_frame_assembler: three instances (default, timeout-discard,
// timeout-pad) driven by directed sequences; delivered frames are checked by
// a scoreboard monitor at every handshake.
module tb_uart_frame_assembler;

  localparam logic [127:0] FRAME_A = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] FRAME_B = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
  localparam logic [127:0] FRESH   = 128'h6F6E6D6C_6B6A6968_67666564_63626160;
  localparam logic [127:0] PADDED  = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_BBAA;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush [3];
  logic         bv    [3];
  logic [7:0]   bd    [3];
  logic         fr    [3];
  logic [127:0] fd    [3];
  logic         fv    [3];
  logic [4:0]   bc    [3];
  logic [15:0]  fc    [3];
  logic         ov    [3];
  logic         te    [3];

  typedef struct {
    int           d;
    logic [127:0] data;
  } exp_t;

  exp_t sb [$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  uart_frame_assembler u_dut0 (
    .clk (clk), .rst_n (rst_n), .flush (flush[0]), .byte_valid (bv[0]), .byte_data (bd[0]),
    .frame_data (fd[0]), .frame_valid (fv[0]), .frame_ready (fr[0]), .byte_count (bc[0]),
    .frame_count (fc[0]), .overflow (ov[0]), .timeout_err (te[0])
  );

  uart_frame_assembler #(.TIMEOUT_CYCLES(100), .PAD_ON_TIMEOUT(0)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .flush (flush[1]), .byte_valid (bv[1]), .byte_data (bd[1]),
    .frame_data (fd[1]), .frame_valid (fv[1]), .frame_ready (fr[1]), .byte_count (bc[1]),
    .frame_count (fc[1]), .overflow (ov[1]), .timeout_err (te[1])
  );

  uart_frame_assembler #(.TIMEOUT_CYCLES(100), .PAD_ON_TIMEOUT(1), .PAD_BYTE(8'hFF)) u_dut2 (
    .clk (clk), .rst_n (rst_n), .flush (flush[2]), .byte_valid (bv[2]), .byte_data (bd[2]),
    .frame_data (fd[2]), .frame_valid (fv[2]), .frame_ready (fr[2]), .byte_count (bc[2]),
    .frame_count (fc[2]), .overflow (ov[2]), .timeout_err (te[2])
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic send(input int d, input logic [7:0] b);
    bv[d] = 1'b1;
    bd[d] = b;
    @(posedge clk);
    #1;
    bv[d] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      bv[d]    = 1'b0;
      flush[d] = 1'b0;
      fr[d]    = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_timeout(input int d, input int expect_cyc, input logic expect_frame);
    int   first      = -1;
    int   pulses     = 0;
    logic frame_seen = 1'b0;
    for (int k = 1; k <= expect_cyc + 20; k++) begin
      @(posedge clk);
      #1;
      if (te[d]) begin
        pulses++;
        if (first < 0) begin
          first      = k;
          frame_seen = fv[d];
        end
      end
    end
    chk($sformatf("dut%0d_timeout_cycle", d), 128'(first), 128'(expect_cyc));
    chk($sformatf("dut%0d_timeout_pulses", d), 128'(pulses), 128'd1);
    chk($sformatf("dut%0d_timeout_byte_count", d), 128'(bc[d]), 128'd0);
    chk($sformatf("dut%0d_timeout_frame", d), 128'(frame_seen), 128'(expect_frame));
  endtask

  // Scoreboard monitor: every handshake must match the oldest expected frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int d = 0; d < 3; d++) begin
          if (fv[d] && fr[d]) begin
            n_cmp++;
            if (sb.size() == 0) begin
              n_err++;
              $display("FAIL handshake dut%0d: got frame %0h, none expected", d, fd[d]);
            end else begin
              e = sb.pop_front();
              if (e.d != d || e.data !== fd[d]) begin
                n_err++;
                $display("FAIL handshake dut%0d: got %0h expected dut%0d %0h", d, fd[d], e.d, e.data);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: time limit reached before end of test");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) bd[d] = 8'h00;
    do_reset();

    // reset values on all instances
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("dut%0d_rst_frame_valid", d), 128'(fv[d]), 128'd0);
      chk($sformatf("dut%0d_rst_frame_data", d), fd[d], 128'd0);
      chk($sformatf("dut%0d_rst_byte_count", d), 128'(bc[d]), 128'd0);
      chk($sformatf("dut%0d_rst_frame_count", d), 128'(fc[d]), 128'd0);
      chk($sformatf("dut%0d_rst_overflow", d), 128'(ov[d]), 128'd0);
      chk($sformatf("dut%0d_rst_timeout_err", d), 128'(te[d]), 128'd0);
    end

    // basic frame, consumer always ready
    fr[0] = 1'b1;
    sb.push_back('{0, FRAME_A});
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("t1_valid_before_last", 128'(fv[0]), 128'd0);
      send(0, 8'(i));
    end
    chk("t1_valid_latency", 128'(fv[0]), 128'd1);
    chk("t1_byte_count", 128'(bc[0]), 128'd0);
    @(posedge clk);
    #1;
    chk("t1_frame_count", 128'(fc[0]), 128'd1);
    chk("t1_valid_fall", 128'(fv[0]), 128'd0);

    // consumer stalled: second frame is dropped
    do_reset();
    sb.push_back('{0, FRAME_A});
    for (int i = 0; i < 32; i++) begin
      send(0, 8'(i));
      if (i == 15) begin
        chk("t2_overflow_early", 128'(ov[0]), 128'd0);
        chk("t2_data_a", fd[0], FRAME_A);
      end
    end
    chk("t2_overflow", 128'(ov[0]), 128'd1);
    chk("t2_data_held", fd[0], FRAME_A);
    chk("t2_valid_held", 128'(fv[0]), 128'd1);
    fr[0] = 1'b1;
    @(posedge clk);
    #1;
    fr[0] = 1'b0;
    chk("t2_frame_count", 128'(fc[0]), 128'd1);
    chk("t2_valid_fall", 128'(fv[0]), 128'd0);

    // last byte of B coincides with acceptance of A
    do_reset();
    sb.push_back('{0, FRAME_A});
    for (int i = 0; i < 16; i++) send(0, 8'(i));
    sb.push_back('{0, FRAME_B});
    for (int i = 16; i < 31; i++) send(0, 8'(i));
    fr[0] = 1'b1;
    send(0, 8'h1F);
    fr[0] = 1'b0;
    chk("t3_valid_stays", 128'(fv[0]), 128'd1);
    chk("t3_data_b", fd[0], FRAME_B);
    chk("t3_no_overflow", 128'(ov[0]), 128'd0);
    chk("t3_frame_count", 128'(fc[0]), 128'd1);
    flush[0] = 1'b1;
    @(posedge clk);
    #1;
    flush[0] = 1'b0;
    chk("t3_flush_keeps_valid", 128'(fv[0]), 128'd1);
    chk("t3_flush_keeps_data", fd[0], FRAME_B);
    fr[0] = 1'b1;
    @(posedge clk);
    #1;
    fr[0] = 1'b0;
    chk("t3_frame_count_2", 128'(fc[0]), 128'd2);

    // reset mid-frame loses the partial frame
    do_reset();
    fr[0] = 1'b1;
    for (int i = 0; i < 7; i++) send(0, 8'(8'h50 + i));
    chk("t6_partial_count", 128'(bc[0]), 128'd7);
    do_reset();
    fr[0] = 1'b1;
    chk("t6_reset_count", 128'(bc[0]), 128'd0);
    sb.push_back('{0, FRESH});
    for (int i = 0; i < 16; i++) send(0, 8'(8'h60 + i));
    @(posedge clk);
    #1;
    chk("t6_frame_count", 128'(fc[0]), 128'd1);

    // flush (together with a byte) discards the partial frame
    do_reset();
    fr[0] = 1'b1;
    for (int i = 0; i < 3; i++) send(0, 8'(8'h40 + i));
    flush[0] = 1'b1;
    bv[0]    = 1'b1;
    bd[0]    = 8'h77;
    @(posedge clk);
    #1;
    flush[0] = 1'b0;
    bv[0]    = 1'b0;
    chk("t7_flush_count", 128'(bc[0]), 128'd0);
    sb.push_back('{0, FRESH});
    for (int i = 0; i < 16; i++) send(0, 8'(8'h60 + i));
    @(posedge clk);
    #1;
    chk("t7_frame_count", 128'(fc[0]), 128'd1);

    // timeout, discard mode
    do_reset();
    fr[1] = 1'b1;
    for (int i = 1; i <= 5; i++) send(1, 8'(i));
    chk("t4_byte_count", 128'(bc[1]), 128'd5);
    wait_timeout(1, 100, 1'b0);
    chk("t4_frame_count", 128'(fc[1]), 128'd0);

    // a byte on the timeout cycle wins and restarts the idle count
    send(1, 8'h11);
    send(1, 8'h22);
    repeat (99) @(posedge clk);
    #1;
    send(1, 8'h33);
    chk("t4b_no_timeout", 128'(te[1]), 128'd0);
    chk("t4b_byte_count", 128'(bc[1]), 128'd3);
    wait_timeout(1, 100, 1'b0);

    // timeout, pad mode
    do_reset();
    fr[2] = 1'b1;
    sb.push_back('{2, PADDED});
    send(2, 8'hAA);
    send(2, 8'hBB);
    wait_timeout(2, 100, 1'b1);
    chk("t5_frame_count", 128'(fc[2]), 128'd1);

    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
